button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 250000, number of consecutive stable samples needed to accept a level change (10 ms at 25 MHz).
REQ-002 Parameter: REPEAT_DELAY, default 12500000, cycles from the first move pulse to the first auto-repeat pulse.
REQ-003 Parameter: REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 clk_25MHz  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_right_raw  input  1  asynchronous, bouncy right button, active-high.
REQ-007 btn_left_raw  input  1  asynchronous, bouncy left button, active-high.
REQ-008 btn_drop_raw  input  1  asynchronous, bouncy drop button, active-high.
REQ-009 move_right  output  1  registered one-cycle pulse feeding the game's move_right.
REQ-010 move_left  output  1  registered one-cycle pulse feeding the game's move_left.
REQ-011 drop_piece  output  1  registered one-cycle pulse feeding the game's drop_piece.
REQ-012 btn_level  output  3  debounced levels {drop, left, right}, registered.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each channel SHALL have a debounce counter, width $clog2(DEBOUNCE_CYCLES+1): it increments while the synchronized value differs from btn_level, clears when they match, and btn_level toggles (counter clears) on the edge where DEBOUNCE_CYCLES consecutive mismatches are reached.
REQ-015 Latency: raw rising held steady from sample edge k SHALL produce btn_level high and the press pulse during the cycle after edge k+DEBOUNCE_CYCLES+2; pulse width exactly 1 cycle.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change and no pulse.
REQ-017 drop_piece SHALL pulse once per debounced rising edge of drop; no auto-repeat; release produces no pulse.
REQ-018 Left/right SHALL share one repeat FSM with states IDLE, WAIT, REPEAT and a single timer of width $clog2(REPEAT_DELAY+1).
REQ-019 IDLE -> WAIT on a debounced rising edge of exactly one of left/right while the other is low: emit one pulse on that direction, clear the timer, latch the direction.
REQ-020 WAIT: timer increments; on reaching REPEAT_DELAY-1 emit a pulse, clear the timer, go to REPEAT.
REQ-021 REPEAT: timer increments; on reaching REPEAT_PERIOD-1 emit a pulse and clear the timer; remain in REPEAT.
REQ-022 From WAIT or REPEAT: release of the latched direction, or the other direction's level going high, SHALL return to IDLE immediately, with no pulse in that cycle.
REQ-023 In IDLE, a held direction SHALL NOT pulse; a new debounced rising edge is required, so releasing one of two held buttons produces nothing.
REQ-024 Simultaneous debounced rising edges of left and right SHALL produce no pulse and stay in IDLE.
REQ-025 move_left and move_right SHALL never be high in the same cycle; drop_piece is independent and may coincide with either.
REQ-026 Parameter legality: DEBOUNCE_CYCLES >= 1, REPEAT_PERIOD >= 2, REPEAT_DELAY >= REPEAT_PERIOD; other values are unsupported.

Reset
REQ-027 While rst is high at a clock edge, synchronizers, debounce counters, btn_level, timer, and all outputs SHALL be 0, and the FSM SHALL be IDLE.
REQ-028 Reset mid-hold SHALL force outputs to 0 on the next edge; a button still held after reset deasserts SHALL be treated as a fresh press (pulse after full debounce latency).

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 Right raw steps 0->1 sampled at edge k, held 10 cycles -> move_right high exactly one cycle after edge k+6, btn_level[0]=1; no other pulses.
REQ-030 Left raw toggles every 2 cycles for 30 cycles then returns to 0 -> no pulse and btn_level stays 0.
REQ-031 Left held 60 cycles -> move_left pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (t0 = first pulse); nothing after release.
REQ-032 Drop held 100 cycles -> exactly one drop_piece pulse; a second press after release -> one more pulse.
REQ-033 Right pressed (one pulse), left pressed 10 cycles later and both held 40 cycles -> no further pulses; right released -> still none until left re-pressed.
REQ-034 Left held into REPEAT, rst pulsed 1 cycle while left stays held -> outputs 0 the cycle after reset, then one move_left pulse 6 edges after reset release, then the repeat sequence of REQ-031.

Source files
------------

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Signal bundle between the raw push-buttons and the game core.
//               master : drives the raw buttons, observes the conditioned
//                        pulses and debounced levels.
//               slave  : the button_conditioner itself.
//               Signals:
//                 btn_right_raw / btn_left_raw / btn_drop_raw
//                              - asynchronous, bouncy, active-high buttons
//                 move_right / move_left / drop_piece
//                              - one-cycle registered command pulses
//                 btn_level[2:0]
//                              - debounced levels {drop, left, right}
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
    logic       btn_right_raw;
    logic       btn_left_raw;
    logic       btn_drop_raw;
    logic       move_right;
    logic       move_left;
    logic       drop_piece;
    logic [2:0] btn_level;

    modport master (
        output btn_right_raw,
        output btn_left_raw,
        output btn_drop_raw,
        input  move_right,
        input  move_left,
        input  drop_piece,
        input  btn_level
    );

    modport slave (
        input  btn_right_raw,
        input  btn_left_raw,
        input  btn_drop_raw,
        output move_right,
        output move_left,
        output drop_piece,
        output btn_level
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises and debounces three push-buttons and turns them
//               into single-cycle game commands. Left/right share one
//               auto-repeat state machine (first pulse on press, a second
//               after REPEAT_DELAY, then one every REPEAT_PERIOD); drop
//               pulses once per press.
//               Ports:
//                 clk_25MHz - sole clock, rising edge
//                 rst       - synchronous active-high reset
//                 bus       - button_conditioner_if.slave (raw buttons in,
//                             pulses and debounced levels out)
//               Supported parameters: DEBOUNCE_CYCLES >= 1,
//               REPEAT_PERIOD >= 2, REPEAT_DELAY >= REPEAT_PERIOD.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  wire logic           clk_25MHz,
    input  wire logic           rst,
    button_conditioner_if.slave bus
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TMR_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_TMR_W-1:0] c_DELAY_M1  = c_TMR_W'(REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_M1 = c_TMR_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    // Channel order everywhere: bit 0 = right, bit 1 = left, bit 2 = drop.
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_btn_level;
    logic [2:0] w_lvl_nxt;
    logic [2:0] w_rise;

    assign w_raw = {bus.btn_drop_raw, bus.btn_left_raw, bus.btn_right_raw};

    // ------------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce counters. The counter holds the number of consecutive
    // mismatches already seen; once it holds DEBOUNCE_CYCLES and the input
    // still disagrees, the level is flipped on that edge. This gives a
    // press-to-pulse latency of DEBOUNCE_CYCLES+2 edges from the first
    // synchroniser sample.
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 3; g++) begin : g_chan
            logic [c_CNT_W-1:0] r_cnt;
            logic               w_mismatch;
            logic               w_accept;

            assign w_mismatch = r_sync2[g] ^ r_btn_level[g];
            assign w_accept   = w_mismatch && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clk_25MHz) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (!w_mismatch || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_lvl_nxt[g] = r_btn_level[g] ^ w_accept;
            assign w_rise[g]    = w_accept & ~r_btn_level[g];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shared left/right repeat FSM. It works on the levels being loaded this
    // edge so that a release or an opposing press cancels any pulse that
    // would otherwise fire on the same edge.
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_dir;          // 1 = left, 0 = right
    logic               w_dir_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               w_fire;
    logic               w_held;
    logic               w_other;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_fire      = 1'b0;
        w_held      = r_dir ? w_lvl_nxt[1] : w_lvl_nxt[0];
        w_other     = r_dir ? w_lvl_nxt[0] : w_lvl_nxt[1];

        case (r_state)
            c_IDLE: begin
                // A fresh edge is required; a held button or a press while
                // the opposite direction is high (incl. simultaneous) is ignored.
                if (w_rise[0] && !w_lvl_nxt[1]) begin
                    w_fire      = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_timer_nxt = '0;
                    w_state_nxt = c_WAIT;
                end else if (w_rise[1] && !w_lvl_nxt[0]) begin
                    w_fire      = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT, c_REPEAT: begin
                if (!w_held || w_other) begin
                    w_timer_nxt = '0;
                    w_state_nxt = c_IDLE;
                end else if (r_timer == ((r_state == c_WAIT) ? c_DELAY_M1 : c_PERIOD_M1)) begin
                    w_fire      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_dir   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs. A single fire strobe steered by direction keeps
    // move_left and move_right mutually exclusive by construction.
    // ------------------------------------------------------------------------
    logic r_move_right;
    logic r_move_left;
    logic r_drop_piece;

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_btn_level  <= '0;
            r_move_right <= 1'b0;
            r_move_left  <= 1'b0;
            r_drop_piece <= 1'b0;
        end else begin
            r_btn_level  <= w_lvl_nxt;
            r_move_right <= w_fire & ~w_dir_nxt;
            r_move_left  <= w_fire & w_dir_nxt;
            r_drop_piece <= w_rise[2];
        end
    end

    assign bus.btn_level  = r_btn_level;
    assign bus.move_right = r_move_right;
    assign bus.move_left  = r_move_left;
    assign bus.drop_piece = r_drop_piece;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//               Each scenario counts clock edges i = 1, 2, ...; the raw input
//               set before step i is first sampled at edge i, and outputs are
//               checked 1 ns after every edge against hand-derived values
//               packed as {btn_level[2:0], drop_piece, move_left, move_right}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk_25MHz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input int idx, input logic [5:0] exp);
        logic [5:0] obs;
        @(posedge clk);
        #1;
        obs = {bus.btn_level, bus.drop_piece, bus.move_left, bus.move_right};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] lvl;
        logic       d;
        logic       l;
        logic       r;

        n_cmp             = 0;
        n_bad             = 0;
        rst               = 1'b1;
        bus.btn_right_raw = 1'b0;
        bus.btn_left_raw  = 1'b0;
        bus.btn_drop_raw  = 1'b0;

        // Reset state
        for (int i = 1; i <= 3; i++) step("reset", i, 6'b0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) step("idle", i, 6'b0);

        // Right press held 10 cycles: one pulse at edge 7, no repeat
        for (int i = 1; i <= 22; i++) begin
            bus.btn_right_raw = (i <= 10);
            lvl = {2'b00, 1'((i >= 7) && (i <= 16))};
            r   = (i == 7);
            step("right_tap", i, {lvl, 1'b0, 1'b0, r});
        end

        // Left bouncing every 2 cycles: never accepted
        for (int i = 1; i <= 38; i++) begin
            bus.btn_left_raw = (i <= 30) && (((i - 1) / 2) % 2 == 0);
            step("left_bounce", i, 6'b0);
        end

        // Left held 60 cycles: first pulse, delay, then periodic repeat
        for (int i = 1; i <= 80; i++) begin
            bus.btn_left_raw = (i <= 60);
            lvl = {1'b0, 1'((i >= 7) && (i <= 66)), 1'b0};
            l   = (i inside {7, 27, 35, 43, 51, 59});
            step("left_repeat", i, {lvl, 1'b0, l, 1'b0});
        end

        // Drop held 100 cycles, released, pressed again: one pulse per press
        for (int i = 1; i <= 145; i++) begin
            bus.btn_drop_raw = (i <= 100) || ((i >= 111) && (i <= 130));
            lvl = {1'(((i >= 7) && (i <= 106)) || ((i >= 117) && (i <= 136))), 2'b00};
            d   = (i == 7) || (i == 117);
            step("drop", i, {lvl, d, 1'b0, 1'b0});
        end

        // Right then left held together; releases; left re-pressed
        for (int i = 1; i <= 115; i++) begin
            bus.btn_right_raw = (i <= 50);
            bus.btn_left_raw  = ((i >= 11) && (i <= 70)) || ((i >= 86) && (i <= 100));
            lvl = {1'b0,
                   1'(((i >= 17) && (i <= 76)) || ((i >= 92) && (i <= 106))),
                   1'((i >= 7) && (i <= 56))};
            r   = (i == 7);
            l   = (i == 92);
            step("both", i, {lvl, 1'b0, l, r});
        end

        // Left held into REPEAT, one-cycle reset, fresh press afterwards
        for (int i = 1; i <= 100; i++) begin
            rst              = (i == 38);
            bus.btn_left_raw = (i <= 85);
            lvl = {1'b0, 1'(((i >= 7) && (i <= 37)) || ((i >= 45) && (i <= 91))), 1'b0};
            l   = (i inside {7, 27, 35, 45, 65, 73, 81, 89});
            step("mid_reset", i, {lvl, 1'b0, l, 1'b0});
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
